// File: rtl/pipe_ctrl_unit.sv
// pipe_ctrl_unit: pipelined control unit. Decodes one instruction per cycle
// from IF/ID into a control bundle and carries it through EX, MEM and WB.
// Inserts a bubble on load-use hazards, discards the decode-stage
// instruction on a taken branch, flags illegal opcodes (sticky) and keeps
// a saturating count of stall cycles.
//
// Build option: define CTRL_HAZARD_EN to enable load-use detection, the
// decode stall and the stall counter. Without it in_ready is always 1 and
// stall_cnt reads 0.

module pipe_ctrl_unit #(
    parameter int unsigned OPW = 4,
    parameter int unsigned RW  = 3,
    parameter int unsigned CW  = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    // IF/ID handshake
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [OPW-1:0] in_op,
    input  logic [RW-1:0]  in_rd,
    input  logic [RW-1:0]  in_rs1,
    input  logic [RW-1:0]  in_rs2,
    // branch resolution from EX
    input  logic           br_taken,
    // EX bundle
    output logic           ex_valid,
    output logic           ex_alu_src,
    output logic           ex_mreg,
    output logic [1:0]     ex_alu_op,
    // MEM bundle
    output logic           mem_valid,
    output logic           mem_mr,
    output logic           mem_mw,
    // WB bundle
    output logic           wb_valid,
    output logic           wb_en_rw,
    output logic           wb_memtoreg,
    output logic [RW-1:0]  wb_rd,
    // status
    output logic           illegal,
    input  logic           illegal_clr,
    output logic [CW-1:0]  stall_cnt
);

    localparam logic [3:0] OP_ADD   = 4'b0000;
    localparam logic [3:0] OP_SUB   = 4'b0001;
    localparam logic [3:0] OP_OR    = 4'b0011;
    localparam logic [3:0] OP_SW    = 4'b0111;
    localparam logic [3:0] OP_NANDI = 4'b1111;
    localparam logic [3:0] OP_LW    = 4'b1101;
    localparam logic [3:0] OP_BR    = 4'b1100;

    // decode results for the instruction sitting in IF/ID
    logic       op_hi_nz;
    logic       dec_legal;
    logic [1:0] dec_alu_op;
    logic       dec_alu_src;
    logic       dec_mreg;
    logic       dec_en_rw;
    logic       dec_memtoreg;
    logic       dec_mr;
    logic       dec_mw;
    logic       dec_is_lw;
    logic       dec_use_rs2;

    // handshake / hazard
    logic       hazard;
    logic       ready;
    logic       take;
    logic       load_ex;

    // EX stage register
    logic          ex_valid_q,    ex_valid_d;
    logic [1:0]    ex_alu_op_q,   ex_alu_op_d;
    logic          ex_alu_src_q,  ex_alu_src_d;
    logic          ex_mreg_q,     ex_mreg_d;
    logic          ex_en_rw_q,    ex_en_rw_d;
    logic          ex_memtoreg_q, ex_memtoreg_d;
    logic          ex_mr_q,       ex_mr_d;
    logic          ex_mw_q,       ex_mw_d;
    logic          ex_is_lw_q,    ex_is_lw_d;
    logic [RW-1:0] ex_rd_q,       ex_rd_d;

    // MEM stage register
    logic          mem_valid_q,    mem_valid_d;
    logic          mem_mr_q,       mem_mr_d;
    logic          mem_mw_q,       mem_mw_d;
    logic          mem_en_rw_q,    mem_en_rw_d;
    logic          mem_memtoreg_q, mem_memtoreg_d;
    logic [RW-1:0] mem_rd_q,       mem_rd_d;

    // WB stage register
    logic          wb_valid_q,    wb_valid_d;
    logic          wb_en_rw_q,    wb_en_rw_d;
    logic          wb_memtoreg_q, wb_memtoreg_d;
    logic [RW-1:0] wb_rd_q,       wb_rd_d;

    // sticky illegal flag
    logic illegal_q, illegal_d;

    // opcode bits above the decoded nibble must be zero
    if (OPW > 4) begin : g_op_hi
        assign op_hi_nz = |in_op[OPW-1:4];
    end else begin : g_op_no_hi
        assign op_hi_nz = 1'b0;
    end

    // opcode decode: every control not listed for an opcode stays 0
    always_comb begin
        dec_legal    = 1'b1;
        dec_alu_op   = 2'b00;
        dec_alu_src  = 1'b0;
        dec_mreg     = 1'b0;
        dec_en_rw    = 1'b0;
        dec_memtoreg = 1'b0;
        dec_mr       = 1'b0;
        dec_mw       = 1'b0;
        dec_is_lw    = 1'b0;
        dec_use_rs2  = 1'b0;
        case (in_op[3:0])
            OP_ADD: begin
                dec_alu_op   = 2'b00;
                dec_mreg     = 1'b1;
                dec_en_rw    = 1'b1;
                dec_memtoreg = 1'b1;
                dec_use_rs2  = 1'b1;
            end
            OP_SUB: begin
                dec_alu_op   = 2'b01;
                dec_mreg     = 1'b1;
                dec_en_rw    = 1'b1;
                dec_memtoreg = 1'b1;
                dec_use_rs2  = 1'b1;
            end
            OP_OR: begin
                dec_alu_op   = 2'b10;
                dec_mreg     = 1'b1;
                dec_en_rw    = 1'b1;
                dec_memtoreg = 1'b1;
                dec_use_rs2  = 1'b1;
            end
            OP_SW: begin
                dec_alu_src  = 1'b1;
                dec_memtoreg = 1'b1;
                dec_mw       = 1'b1;
                dec_use_rs2  = 1'b1;
            end
            OP_NANDI: begin
                dec_alu_op   = 2'b11;
                dec_alu_src  = 1'b1;
                dec_en_rw    = 1'b1;
                dec_memtoreg = 1'b1;
            end
            OP_LW: begin
                dec_alu_src  = 1'b1;
                dec_en_rw    = 1'b1;
                dec_mr       = 1'b1;
                dec_is_lw    = 1'b1;
            end
            OP_BR: begin
                dec_alu_src  = 1'b1;
                dec_mr       = 1'b1;
            end
            default: begin
                dec_legal    = 1'b0;
            end
        endcase
        if (op_hi_nz) begin
            dec_legal = 1'b0;
        end
    end

`ifdef CTRL_HAZARD_EN
    // load-use hazard: LW in EX writes a register the decode instruction reads
    always_comb begin
        hazard = 1'b0;
        if (in_valid && dec_legal && ex_valid_q && ex_is_lw_q) begin
            hazard = (ex_rd_q == in_rs1) || (dec_use_rs2 && (ex_rd_q == in_rs2));
        end
    end
`else
    // software schedules LW consumers, so decode never stalls
    logic unused_hazard_inputs;
    assign unused_hazard_inputs = ^{in_rs1, in_rs2, dec_use_rs2, ex_is_lw_q};
    assign hazard = 1'b0;
`endif

    // a taken branch always drains IF/ID, so it overrides a stall
    assign ready    = br_taken || !hazard;
    assign in_ready = ready;
    assign take     = in_valid && ready && !br_taken;
    assign load_ex  = take && dec_legal;

    // next-state for the EX/MEM/WB registers and the illegal flag
    always_comb begin
        ex_valid_d    = load_ex;
        ex_alu_op_d   = load_ex ? dec_alu_op   : 2'b00;
        ex_alu_src_d  = load_ex && dec_alu_src;
        ex_mreg_d     = load_ex && dec_mreg;
        ex_en_rw_d    = load_ex && dec_en_rw;
        ex_memtoreg_d = load_ex && dec_memtoreg;
        ex_mr_d       = load_ex && dec_mr;
        ex_mw_d       = load_ex && dec_mw;
        ex_is_lw_d    = load_ex && dec_is_lw;
        ex_rd_d       = load_ex ? in_rd : RW'(0);

        mem_valid_d    = ex_valid_q;
        mem_mr_d       = ex_mr_q;
        mem_mw_d       = ex_mw_q;
        mem_en_rw_d    = ex_en_rw_q;
        mem_memtoreg_d = ex_memtoreg_q;
        mem_rd_d       = ex_rd_q;

        wb_valid_d    = mem_valid_q;
        wb_en_rw_d    = mem_en_rw_q;
        wb_memtoreg_d = mem_memtoreg_q;
        wb_rd_d       = mem_rd_q;

        illegal_d = illegal_q;
        if (illegal_clr) begin
            illegal_d = 1'b0;
        end else if (take && !dec_legal) begin
            illegal_d = 1'b1;
        end
    end

    // EX stage register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid_q    <= 1'b0;
            ex_alu_op_q   <= 2'b00;
            ex_alu_src_q  <= 1'b0;
            ex_mreg_q     <= 1'b0;
            ex_en_rw_q    <= 1'b0;
            ex_memtoreg_q <= 1'b0;
            ex_mr_q       <= 1'b0;
            ex_mw_q       <= 1'b0;
            ex_is_lw_q    <= 1'b0;
            ex_rd_q       <= RW'(0);
        end else begin
            ex_valid_q    <= ex_valid_d;
            ex_alu_op_q   <= ex_alu_op_d;
            ex_alu_src_q  <= ex_alu_src_d;
            ex_mreg_q     <= ex_mreg_d;
            ex_en_rw_q    <= ex_en_rw_d;
            ex_memtoreg_q <= ex_memtoreg_d;
            ex_mr_q       <= ex_mr_d;
            ex_mw_q       <= ex_mw_d;
            ex_is_lw_q    <= ex_is_lw_d;
            ex_rd_q       <= ex_rd_d;
        end
    end

    // MEM and WB stage registers shift unconditionally
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_valid_q    <= 1'b0;
            mem_mr_q       <= 1'b0;
            mem_mw_q       <= 1'b0;
            mem_en_rw_q    <= 1'b0;
            mem_memtoreg_q <= 1'b0;
            mem_rd_q       <= RW'(0);
            wb_valid_q     <= 1'b0;
            wb_en_rw_q     <= 1'b0;
            wb_memtoreg_q  <= 1'b0;
            wb_rd_q        <= RW'(0);
        end else begin
            mem_valid_q    <= mem_valid_d;
            mem_mr_q       <= mem_mr_d;
            mem_mw_q       <= mem_mw_d;
            mem_en_rw_q    <= mem_en_rw_d;
            mem_memtoreg_q <= mem_memtoreg_d;
            mem_rd_q       <= mem_rd_d;
            wb_valid_q     <= wb_valid_d;
            wb_en_rw_q     <= wb_en_rw_d;
            wb_memtoreg_q  <= wb_memtoreg_d;
            wb_rd_q        <= wb_rd_d;
        end
    end

    // sticky illegal-opcode flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            illegal_q <= 1'b0;
        end else begin
            illegal_q <= illegal_d;
        end
    end

`ifdef CTRL_HAZARD_EN
    logic [CW-1:0] stall_cnt_q, stall_cnt_d;

    // count cycles where a hazard actually held decode (not flushed)
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (hazard && !br_taken && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CW'(1);
        end
    end

    // saturating stall counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= CW'(0);
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`else
    assign stall_cnt = CW'(0);
`endif

    assign ex_valid    = ex_valid_q;
    assign ex_alu_src  = ex_alu_src_q;
    assign ex_mreg     = ex_mreg_q;
    assign ex_alu_op   = ex_alu_op_q;
    assign mem_valid   = mem_valid_q;
    assign mem_mr      = mem_mr_q;
    assign mem_mw      = mem_mw_q;
    assign wb_valid    = wb_valid_q;
    assign wb_en_rw    = wb_en_rw_q;
    assign wb_memtoreg = wb_memtoreg_q;
    assign wb_rd       = wb_rd_q;
    assign illegal     = illegal_q;

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Bench for pipe_ctrl_unit: decode-table vectors, directed multi-cycle
// sequences and a randomized run against a pipeline-array reference model.
// Built with OPW=5 (upper-bit illegal case) and CW=2 (saturation).

module tb_pipe_ctrl_unit;

    localparam int unsigned OPW = 5;
    localparam int unsigned RW  = 3;
    localparam int unsigned CW  = 2;
    localparam int SMAX = 3;

`ifdef CTRL_HAZARD_EN
    localparam bit HZ = 1'b1;
`else
    localparam bit HZ = 1'b0;
`endif

    localparam logic [4:0] ADD   = 5'b00000;
    localparam logic [4:0] SUB   = 5'b00001;
    localparam logic [4:0] OR_   = 5'b00011;
    localparam logic [4:0] SW    = 5'b00111;
    localparam logic [4:0] NANDI = 5'b01111;
    localparam logic [4:0] LW    = 5'b01101;
    localparam logic [4:0] BR    = 5'b01100;

    logic           clk;
    logic           rst_n;
    logic           in_valid;
    logic           in_ready;
    logic [OPW-1:0] in_op;
    logic [RW-1:0]  in_rd, in_rs1, in_rs2;
    logic           br_taken;
    logic           ex_valid, ex_alu_src, ex_mreg;
    logic [1:0]     ex_alu_op;
    logic           mem_valid, mem_mr, mem_mw;
    logic           wb_valid, wb_en_rw, wb_memtoreg;
    logic [RW-1:0]  wb_rd;
    logic           illegal;
    logic           illegal_clr;
    logic [CW-1:0]  stall_cnt;

    pipe_ctrl_unit #(.OPW(OPW), .RW(RW), .CW(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .br_taken(br_taken),
        .ex_valid(ex_valid), .ex_alu_src(ex_alu_src), .ex_mreg(ex_mreg),
        .ex_alu_op(ex_alu_op),
        .mem_valid(mem_valid), .mem_mr(mem_mr), .mem_mw(mem_mw),
        .wb_valid(wb_valid), .wb_en_rw(wb_en_rw), .wb_memtoreg(wb_memtoreg),
        .wb_rd(wb_rd),
        .illegal(illegal), .illegal_clr(illegal_clr), .stall_cnt(stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    logic last_ready;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic       valid;
        logic [1:0] alu_op;
        logic       alu_src, mreg, en_rw, m2r, mr, mw;
        logic       is_lw;
        logic [2:0] rd;
    } ctl_t;

    ctl_t m_pipe [3];   // 0 = EX, 1 = MEM, 2 = WB
    logic m_ill;
    int   m_scnt;

    function automatic ctl_t dec_ref(input logic [4:0] op, input logic [2:0] rd);
        ctl_t c;
        c = '0;
        c.valid = 1'b1;
        case (op)
            ADD:     {c.alu_op, c.alu_src, c.mreg, c.en_rw, c.m2r, c.mr, c.mw} = 8'b00_0_1_1_1_0_0;
            SUB:     {c.alu_op, c.alu_src, c.mreg, c.en_rw, c.m2r, c.mr, c.mw} = 8'b01_0_1_1_1_0_0;
            OR_:     {c.alu_op, c.alu_src, c.mreg, c.en_rw, c.m2r, c.mr, c.mw} = 8'b10_0_1_1_1_0_0;
            SW:      {c.alu_op, c.alu_src, c.mreg, c.en_rw, c.m2r, c.mr, c.mw} = 8'b00_1_0_0_1_0_1;
            NANDI:   {c.alu_op, c.alu_src, c.mreg, c.en_rw, c.m2r, c.mr, c.mw} = 8'b11_1_0_1_1_0_0;
            LW:      {c.alu_op, c.alu_src, c.mreg, c.en_rw, c.m2r, c.mr, c.mw} = 8'b00_1_0_1_0_1_0;
            BR:      {c.alu_op, c.alu_src, c.mreg, c.en_rw, c.m2r, c.mr, c.mw} = 8'b00_1_0_0_0_1_0;
            default: c.valid = 1'b0;
        endcase
        if (c.valid) begin
            c.rd    = rd;
            c.is_lw = (op == LW);
        end
        return c;
    endfunction

    function automatic logic uses_rs2(input logic [4:0] op);
        return (op == ADD) || (op == SUB) || (op == OR_) || (op == SW);
    endfunction

    function automatic logic m_hazard(input logic v, input logic [4:0] op,
                                      input logic [2:0] rs1, input logic [2:0] rs2);
        ctl_t d;
        d = dec_ref(op, 3'd0);
        if (!HZ) return 1'b0;
        return v && d.valid && m_pipe[0].valid && m_pipe[0].is_lw &&
               ((m_pipe[0].rd == rs1) || (uses_rs2(op) && (m_pipe[0].rd == rs2)));
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 3; i++) m_pipe[i] = '0;
        m_ill  = 1'b0;
        m_scnt = 0;
    endtask

    task automatic m_step(input logic v, input logic [4:0] op, input logic [2:0] rd,
                          input logic [2:0] rs1, input logic [2:0] rs2,
                          input logic br, input logic clr);
        logic hz, acc;
        ctl_t d;
        hz  = m_hazard(v, op, rs1, rs2);
        acc = v && (br || !hz) && !br;
        d   = dec_ref(op, rd);
        m_pipe[2] = m_pipe[1];
        m_pipe[1] = m_pipe[0];
        m_pipe[0] = acc ? d : ctl_t'(0);
        if (clr) m_ill = 1'b0;
        else if (acc && !d.valid) m_ill = 1'b1;
        if (hz && !br && m_scnt < SMAX) m_scnt++;
    endtask

    task automatic check_outputs();
        chk("ex_valid",    ex_valid,    m_pipe[0].valid);
        chk("ex_alu_op",   ex_alu_op,   m_pipe[0].alu_op);
        chk("ex_alu_src",  ex_alu_src,  m_pipe[0].alu_src);
        chk("ex_mreg",     ex_mreg,     m_pipe[0].mreg);
        chk("mem_valid",   mem_valid,   m_pipe[1].valid);
        chk("mem_mr",      mem_mr,      m_pipe[1].mr);
        chk("mem_mw",      mem_mw,      m_pipe[1].mw);
        chk("wb_valid",    wb_valid,    m_pipe[2].valid);
        chk("wb_en_rw",    wb_en_rw,    m_pipe[2].en_rw);
        chk("wb_memtoreg", wb_memtoreg, m_pipe[2].m2r);
        chk("wb_rd",       wb_rd,       m_pipe[2].rd);
        chk("illegal",     illegal,     m_ill);
        chk("stall_cnt",   stall_cnt,   m_scnt);
    endtask

    // one clock: drive at edge+1, check in_ready at negedge, check state after edge
    task automatic cycle(input logic v, input logic [4:0] op, input logic [2:0] rd,
                         input logic [2:0] rs1, input logic [2:0] rs2,
                         input logic br, input logic clr);
        logic exp_rdy;
        in_valid = v; in_op = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
        br_taken = br; illegal_clr = clr;
        @(negedge clk);
        exp_rdy = br || !m_hazard(v, op, rs1, rs2);
        last_ready = in_ready;
        chk("in_ready", in_ready, exp_rdy);
        @(posedge clk);
        m_step(v, op, rd, rs1, rs2, br, clr);
        #1;
        check_outputs();
    endtask

    task automatic idle();
        cycle(1'b0, 5'd0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        in_valid = 1'b0; in_op = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0;
        br_taken = 1'b0; illegal_clr = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        m_reset();
        check_outputs();
        chk("rst_in_ready", in_ready, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // decode-table vectors: op, expected valid, {alu_op,alu_src,mreg,en_rw,m2r,mr,mw}
    typedef struct {
        logic [4:0] op;
        logic       v;
        logic [7:0] ctl;
    } vec_t;

    vec_t vecs [9];

    initial begin
        vecs[0] = '{ADD,      1'b1, 8'b00_0_1_1_1_0_0};
        vecs[1] = '{SUB,      1'b1, 8'b01_0_1_1_1_0_0};
        vecs[2] = '{OR_,      1'b1, 8'b10_0_1_1_1_0_0};
        vecs[3] = '{SW,       1'b1, 8'b00_1_0_0_1_0_1};
        vecs[4] = '{NANDI,    1'b1, 8'b11_1_0_1_1_0_0};
        vecs[5] = '{LW,       1'b1, 8'b00_1_0_1_0_1_0};
        vecs[6] = '{BR,       1'b1, 8'b00_1_0_0_0_1_0};
        vecs[7] = '{5'b00101, 1'b0, 8'b00_0_0_0_0_0_0};
        vecs[8] = '{5'b10000, 1'b0, 8'b00_0_0_0_0_0_0};

        rst_n = 1'b0;
        m_reset();
        do_reset();

        // decode table through all three stages
        for (int i = 0; i < 9; i++) begin
            cycle(1'b1, vecs[i].op, 3'd5, 3'd6, 3'd6, 1'b0, 1'b0);
            chk("vec_ex_valid", ex_valid, vecs[i].v);
            chk("vec_ex_ctl", {ex_alu_op, ex_alu_src, ex_mreg},
                {vecs[i].ctl[7:6], vecs[i].ctl[5], vecs[i].ctl[4]});
            idle();
            chk("vec_mem_ctl", {mem_valid, mem_mr, mem_mw},
                {vecs[i].v, vecs[i].ctl[1], vecs[i].ctl[0]});
            idle();
            chk("vec_wb_ctl", {wb_valid, wb_en_rw, wb_memtoreg, wb_rd},
                {vecs[i].v, vecs[i].ctl[3], vecs[i].ctl[2], vecs[i].v ? 3'd5 : 3'd0});
        end
        chk("vec_illegal_sticky", illegal, 1'b1);

        // ADD then SUB back-to-back
        do_reset();
        cycle(1'b1, ADD, 3'd1, 3'd2, 3'd3, 1'b0, 1'b0);
        chk("add_ex_alu_op", ex_alu_op, 2'b00);
        cycle(1'b1, SUB, 3'd2, 3'd2, 3'd3, 1'b0, 1'b0);
        chk("sub_ex_alu_op", ex_alu_op, 2'b01);
        idle();
        chk("add_wb", {wb_valid, wb_en_rw, wb_memtoreg, wb_rd}, {1'b1, 1'b1, 1'b1, 3'd1});

        // LW r4 then OR r6,r4,r5
        do_reset();
        cycle(1'b1, LW, 3'd4, 3'd0, 3'd0, 1'b0, 1'b0);
        cycle(1'b1, OR_, 3'd6, 3'd4, 3'd5, 1'b0, 1'b0);
        chk("lu_ready", last_ready, HZ ? 1'b0 : 1'b1);
        chk("lu_ex_valid", ex_valid, HZ ? 1'b0 : 1'b1);
        chk("lu_mem_lw", mem_mr, 1'b1);
        cycle(1'b1, OR_, 3'd6, 3'd4, 3'd5, 1'b0, 1'b0);
        chk("lu_retry_ready", last_ready, 1'b1);
        chk("lu_retry_op", {ex_valid, ex_alu_op}, {1'b1, 2'b10});
        chk("lu_stall_cnt", stall_cnt, HZ ? 2'd1 : 2'd0);

        // flush coincident with a load-use hazard
        do_reset();
        cycle(1'b1, ADD, 3'd1, 3'd2, 3'd3, 1'b0, 1'b0);
        cycle(1'b1, LW, 3'd4, 3'd0, 3'd0, 1'b0, 1'b0);
        cycle(1'b1, OR_, 3'd6, 3'd4, 3'd5, 1'b1, 1'b0);
        chk("fl_ready", last_ready, 1'b1);
        chk("fl_ex_valid", ex_valid, 1'b0);
        chk("fl_stall_cnt", stall_cnt, 2'd0);
        chk("fl_mem_lw", {mem_valid, mem_mr}, 2'b11);
        chk("fl_wb_add", {wb_valid, wb_rd}, {1'b1, 3'd1});

        // illegal opcode, then clear racing a second illegal
        cycle(1'b1, 5'b00101, 3'd1, 3'd1, 3'd1, 1'b0, 1'b0);
        chk("ill_ex_valid", ex_valid, 1'b0);
        chk("ill_set", illegal, 1'b1);
        cycle(1'b1, 5'b00101, 3'd1, 3'd1, 3'd1, 1'b0, 1'b1);
        chk("ill_clr_wins", illegal, 1'b0);
        cycle(1'b1, ADD, 3'd1, 3'd1, 3'd1, 1'b0, 1'b0);
        chk("ill_stays_clr", illegal, 1'b0);

        // stall counter saturation (CW=2)
        do_reset();
        for (int k = 0; k < 5; k++) begin
            cycle(1'b1, LW, 3'd2, 3'd0, 3'd0, 1'b0, 1'b0);
            cycle(1'b1, OR_, 3'd3, 3'd2, 3'd1, 1'b0, 1'b0);
            cycle(1'b1, OR_, 3'd3, 3'd2, 3'd1, 1'b0, 1'b0);
            if (k == 3) chk("sat_after4", stall_cnt, HZ ? 2'd3 : 2'd0);
        end
        chk("sat_hold", stall_cnt, HZ ? 2'd3 : 2'd0);

        // asynchronous reset during a stall
        cycle(1'b1, ADD, 3'd1, 3'd0, 3'd0, 1'b0, 1'b0);
        cycle(1'b1, LW, 3'd3, 3'd0, 3'd0, 1'b0, 1'b0);
        in_valid = 1'b1; in_op = OR_; in_rd = 3'd6; in_rs1 = 3'd3; in_rs2 = 3'd5;
        br_taken = 1'b0; illegal_clr = 1'b0;
        @(negedge clk);
        chk("ms_ready", in_ready, HZ ? 1'b0 : 1'b1);
        #2 rst_n = 1'b0;
        #1;
        m_reset();
        check_outputs();
        chk("ms_rst_ready", in_ready, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        chk("ms_rel_ready", in_ready, 1'b1);
        @(posedge clk);
        m_step(1'b1, OR_, 3'd6, 3'd3, 3'd5, 1'b0, 1'b0);
        #1;
        check_outputs();
        chk("ms_accept", {ex_valid, ex_alu_op, ex_mreg}, {1'b1, 2'b10, 1'b1});

        // randomized run against the model
        for (int n = 0; n < 1500; n++) begin
            logic [4:0] op;
            int sel;
            sel = $urandom_range(0, 9);
            case (sel)
                0: op = ADD;
                1: op = SUB;
                2: op = OR_;
                3: op = SW;
                4: op = NANDI;
                5: op = BR;
                6: op = 5'($urandom_range(0, 31));
                default: op = LW;
            endcase
            cycle($urandom_range(0, 9) != 0, op,
                  3'($urandom_range(0, 3)), 3'($urandom_range(0, 3)), 3'($urandom_range(0, 3)),
                  $urandom_range(0, 9) == 0, $urandom_range(0, 19) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
